// File: rtl/background_model_acc.sv
// Per-pixel background model.
// TRAIN mode: accumulates the grey-level sum and sum-of-squares for every pixel
// in external SRAM over 2**TRAIN_LOG2 frames (three 16-bit words per pixel).
// DETECT mode: reads the statistics back and flags a pixel as foreground when
// (g-mean)^2 > K_SIGMA2*var + MIN_VAR.
//
// Handshake: a pixel is accepted on a rising clock edge where i_valid && o_ready
// and i_start_train is low; o_ready is high only in S_IDLE, and i_valid must
// hold its pixel until that edge. o_fg_valid is a one-cycle pulse, no back-pressure.
module background_model_acc #(
  parameter int H_MAX      = 640,
  parameter int V_MAX      = 480,
  parameter int TRAIN_LOG2 = 5,
  parameter int K_SIGMA2   = 9,
  parameter int MIN_VAR    = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [9:0]  i_r,
  input  logic [9:0]  i_g,
  input  logic [9:0]  i_b,
  input  logic        i_start_train,
  output logic        o_trained,
  output logic        o_fg_valid,
  output logic        o_fg,
  output logic        o_sram_rd,
  output logic        o_sram_wr,
  output logic [19:0] o_sram_addr,
  inout  wire  [15:0] sram_dq,
  output logic [3:0]  o_dbg_state
);

  // Counter widths (at least one bit each so degenerate sizes still elaborate)
  localparam int HW = (H_MAX > 1) ? $clog2(H_MAX) : 1;
  localparam int VW = (V_MAX > 1) ? $clog2(V_MAX) : 1;
  localparam int FW = TRAIN_LOG2;

  localparam logic [HW-1:0] H_LAST = HW'(H_MAX - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_MAX - 1);
  // Last training frame index is 2**TRAIN_LOG2-1, i.e. all ones
  localparam logic [FW-1:0] F_LAST = '1;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_RD0  = 4'd1,
    S_RD1  = 4'd2,
    S_RD2  = 4'd3,
    S_WR0  = 4'd4,
    S_WR1  = 4'd5,
    S_WR2  = 4'd6,
    S_CMP  = 4'd7
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            detect_q, detect_d;
  logic [7:0]      gray_q, gray_d;
  logic [15:0]     rd0_q, rd0_d;
  logic [15:0]     rd1_q, rd1_d;
  logic [7:0]      rd2_q, rd2_d;
  logic            fg_q, fg_d;
  logic            fg_valid_q, fg_valid_d;

  logic            idle;
  logic            accept;
  logic            restart;
  logic            force_zero;
  logic            pixel_done;
  logic [16:0]     gray_mix;
  logic [7:0]      gray_now;
  logic [19:0]     pix_idx;
  logic [19:0]     base_addr;
  logic [15:0]     gray_sq;
  logic [23:0]     sumsq_old;
  logic [15:0]     sum_new;
  logic [23:0]     sumsq_new;
  logic [15:0]     mean;
  logic [31:0]     mean_sq;
  logic [31:0]     ex2;
  logic [31:0]     var_c;
  logic [15:0]     diff;
  logic [31:0]     diff_sq;
  logic [31:0]     thresh;
  logic            fg_cmp;
  logic [15:0]     wdata;

  // Handshake and control qualifiers; restart wins over a simultaneous pixel
  always_comb begin
    idle       = (state_q == S_IDLE);
    restart    = idle && i_start_train;
    accept     = idle && i_valid && !i_start_train;
    force_zero = !detect_q && (frame_q == '0);
    pixel_done = (state_q == S_WR2) || (state_q == S_CMP);
  end

  // Luma approximation: (38R + 75G + 15B) >> 9, max 130944 fits 17 bits
  always_comb begin
    gray_mix = ({7'd0, i_r} * 17'd38) + ({7'd0, i_g} * 17'd75) + ({7'd0, i_b} * 17'd15);
    gray_now = gray_mix[16:9];
  end

  // SRAM addressing: three words per pixel in raster order
  always_comb begin
    pix_idx   = (20'(v_q) * 20'(H_MAX)) + 20'(h_q);
    base_addr = pix_idx + {pix_idx[18:0], 1'b0};
  end

  // Training update and detection arithmetic, all unsigned and wide enough not to wrap
  always_comb begin
    gray_sq   = {8'd0, gray_q} * {8'd0, gray_q};
    sumsq_old = {rd2_q, rd1_q};
    sum_new   = rd0_q + {8'd0, gray_q};
    sumsq_new = sumsq_old + {8'd0, gray_sq};
    mean      = rd0_q >> TRAIN_LOG2;
    mean_sq   = {16'd0, mean} * {16'd0, mean};
    ex2       = {8'd0, sumsq_old} >> TRAIN_LOG2;
    var_c     = (ex2 > mean_sq) ? (ex2 - mean_sq) : 32'd0;
    diff      = ({8'd0, gray_q} >= mean) ? ({8'd0, gray_q} - mean) : (mean - {8'd0, gray_q});
    diff_sq   = {16'd0, diff} * {16'd0, diff};
    thresh    = (var_c * 32'(K_SIGMA2)) + 32'(MIN_VAR);
    fg_cmp    = (diff_sq > thresh);
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: three reads, then either three writes (TRAIN) or one compare (DETECT)
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_RD0;
      S_RD0:   state_d = S_RD1;
      S_RD1:   state_d = S_RD2;
      S_RD2:   state_d = detect_q ? S_CMP : S_WR0;
      S_WR0:   state_d = S_WR1;
      S_WR1:   state_d = S_WR2;
      S_WR2:   state_d = S_IDLE;
      S_CMP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state: SRAM strobes, address and write data
  always_comb begin
    o_sram_rd   = 1'b0;
    o_sram_wr   = 1'b0;
    o_sram_addr = 20'd0;
    wdata       = 16'd0;
    unique case (state_q)
      S_RD0: begin
        o_sram_rd   = 1'b1;
        o_sram_addr = base_addr;
      end
      S_RD1: begin
        o_sram_rd   = 1'b1;
        o_sram_addr = base_addr + 20'd1;
      end
      S_RD2: begin
        o_sram_rd   = 1'b1;
        o_sram_addr = base_addr + 20'd2;
      end
      S_WR0: begin
        o_sram_wr   = 1'b1;
        o_sram_addr = base_addr;
        wdata       = sum_new;
      end
      S_WR1: begin
        o_sram_wr   = 1'b1;
        o_sram_addr = base_addr + 20'd1;
        wdata       = sumsq_new[15:0];
      end
      S_WR2: begin
        o_sram_wr   = 1'b1;
        o_sram_addr = base_addr + 20'd2;
        wdata       = {8'd0, sumsq_new[23:16]};
      end
      default: begin
        o_sram_rd   = 1'b0;
        o_sram_wr   = 1'b0;
      end
    endcase
  end

  // The data bus is only driven during write states
  assign sram_dq = o_sram_wr ? wdata : 16'bz;

  // Datapath next values: pixel capture, read capture, counters, mode, result
  always_comb begin
    h_d        = h_q;
    v_d        = v_q;
    frame_d    = frame_q;
    detect_d   = detect_q;
    gray_d     = gray_q;
    rd0_d      = rd0_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    fg_d       = fg_q;
    fg_valid_d = 1'b0;

    if (accept) begin
      gray_d = gray_now;
    end

    // On the first training frame the SRAM holds stale data, so start from zero
    if (state_q == S_RD0) rd0_d = force_zero ? 16'd0 : sram_dq;
    if (state_q == S_RD1) rd1_d = force_zero ? 16'd0 : sram_dq;
    if (state_q == S_RD2) rd2_d = force_zero ? 8'd0  : sram_dq[7:0];

    if (state_q == S_CMP) begin
      fg_d       = fg_cmp;
      fg_valid_d = 1'b1;
    end

    if (restart) begin
      h_d      = '0;
      v_d      = '0;
      frame_d  = '0;
      detect_d = 1'b0;
    end else if (pixel_done) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d = '0;
          // Frame wrap: in TRAIN count frames and switch to DETECT after the last one
          if (!detect_q) begin
            if (frame_q == F_LAST) begin
              detect_d = 1'b1;
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_q        <= '0;
      v_q        <= '0;
      frame_q    <= '0;
      detect_q   <= 1'b0;
      gray_q     <= 8'd0;
      rd0_q      <= 16'd0;
      rd1_q      <= 16'd0;
      rd2_q      <= 8'd0;
      fg_q       <= 1'b0;
      fg_valid_q <= 1'b0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      frame_q    <= frame_d;
      detect_q   <= detect_d;
      gray_q     <= gray_d;
      rd0_q      <= rd0_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      fg_q       <= fg_d;
      fg_valid_q <= fg_valid_d;
    end
  end

  // Remaining outputs straight from registers
  always_comb begin
    o_ready     = idle;
    o_trained   = detect_q;
    o_fg        = fg_q;
    o_fg_valid  = fg_valid_q;
    o_dbg_state = state_q;
  end

endmodule

// File: tb/tb_background_model_acc.sv
// Bench for background_model_acc: small frame (4x2), two training frames,
// behavioural asynchronous-read SRAM, reference model of the per-pixel statistics.
module tb_background_model_acc;

  localparam int H_MAX = 4;
  localparam int V_MAX = 2;
  localparam int TRAIN_LOG2 = 1;
  localparam int K_SIGMA2 = 9;
  localparam int MIN_VAR = 16;
  localparam int NPIX = H_MAX * V_MAX;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [9:0]  i_r, i_g, i_b;
  logic        i_start_train;
  logic        o_trained;
  logic        o_fg_valid;
  logic        o_fg;
  logic        o_sram_rd;
  logic        o_sram_wr;
  logic [19:0] o_sram_addr;
  wire  [15:0] sram_dq;
  logic [3:0]  o_dbg_state;

  background_model_acc #(
    .H_MAX(H_MAX), .V_MAX(V_MAX), .TRAIN_LOG2(TRAIN_LOG2),
    .K_SIGMA2(K_SIGMA2), .MIN_VAR(MIN_VAR)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_start_train(i_start_train),
    .o_trained(o_trained), .o_fg_valid(o_fg_valid), .o_fg(o_fg),
    .o_sram_rd(o_sram_rd), .o_sram_wr(o_sram_wr), .o_sram_addr(o_sram_addr),
    .sram_dq(sram_dq), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- SRAM model ----------------
  logic [15:0] mem [0:63];
  logic [15:0] mem_rd;
  always_comb mem_rd = mem[o_sram_addr[5:0]];
  assign sram_dq = o_sram_rd ? mem_rd : 16'hzzzz;
  always @(posedge i_clk) if (o_sram_wr) mem[o_sram_addr[5:0]] <= sram_dq;

  // ---------------- check / counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int ref_sum [0:NPIX-1];
  int ref_sq  [0:NPIX-1];
  int ref_h, ref_v, ref_frame;
  bit ref_detect;
  int cur_idx, rd_k, wr_k;
  bit cur_train, had_px;
  int cyc;
  int low_run, gap_exp;
  bit gap_armed;
  logic [0:0] exp_q[$];
  int         lat_q[$];

  function automatic int gray_of(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    return (38 * int'(r) + 75 * int'(g) + 15 * int'(b)) >> 9;
  endfunction

  function automatic logic [15:0] exp_word(input int k);
    if (k == 0) return 16'(ref_sum[cur_idx] & 16'hffff);
    if (k == 1) return 16'(ref_sq[cur_idx] & 16'hffff);
    return 16'((ref_sq[cur_idx] >> 16) & 16'hffff);
  endfunction

  function automatic bit exp_fg(input int idx, input int g);
    int mean, ex2, msq, var_v, diff;
    mean  = ref_sum[idx] >> TRAIN_LOG2;
    ex2   = ref_sq[idx] >> TRAIN_LOG2;
    msq   = mean * mean;
    var_v = (ex2 > msq) ? ex2 - msq : 0;
    diff  = (g > mean) ? g - mean : mean - g;
    return (diff * diff) > (K_SIGMA2 * var_v + MIN_VAR);
  endfunction

  // Monitor / scoreboard, sampled on the falling edge
  always @(negedge i_clk) begin
    cyc++;
    if (!i_rst_n) begin
      ref_h = 0; ref_v = 0; ref_frame = 0; ref_detect = 0;
      rd_k = 0; wr_k = 0; had_px = 0; low_run = 0; gap_armed = 0;
      exp_q.delete(); lat_q.delete();
    end else begin
      if (o_sram_rd) begin
        check("rd_addr", 32'(o_sram_addr), 32'(3 * cur_idx + rd_k));
        rd_k++;
      end
      if (o_sram_wr) begin
        check("wr_addr", 32'(o_sram_addr), 32'(3 * cur_idx + wr_k));
        check("wr_data", 32'(sram_dq), 32'(exp_word(wr_k)));
        wr_k++;
      end
      if (o_fg_valid) begin
        if (exp_q.size() == 0) begin
          check("fg_unexpected", 32'd1, 32'd0);
        end else begin
          logic [0:0] e;
          int a;
          e = exp_q.pop_front();
          a = lat_q.pop_front();
          check("fg", 32'(o_fg), 32'(e));
          check("fg_latency", 32'(cyc - a), 32'd5);
        end
      end
      if (!o_ready) begin
        low_run++;
      end else if (low_run > 0) begin
        if (gap_armed) check("ready_gap", 32'(low_run), 32'(gap_exp));
        low_run = 0;
      end
      if (o_ready && i_start_train) begin
        ref_h = 0; ref_v = 0; ref_frame = 0; ref_detect = 0;
      end else if (o_ready && i_valid) begin
        int g;
        if (had_px) begin
          check("rd_count", 32'(rd_k), 32'd3);
          check("wr_count", 32'(wr_k), cur_train ? 32'd3 : 32'd0);
        end
        g = gray_of(i_r, i_g, i_b);
        cur_idx = ref_v * H_MAX + ref_h;
        cur_train = !ref_detect;
        rd_k = 0; wr_k = 0; had_px = 1;
        gap_armed = 1;
        gap_exp = ref_detect ? 4 : 6;
        if (ref_detect) begin
          exp_q.push_back(exp_fg(cur_idx, g));
          lat_q.push_back(cyc);
        end else if (ref_frame == 0) begin
          ref_sum[cur_idx] = g;
          ref_sq[cur_idx] = g * g;
        end else begin
          ref_sum[cur_idx] = (ref_sum[cur_idx] + g) & 32'hffff;
          ref_sq[cur_idx] = (ref_sq[cur_idx] + g * g) & 32'hffffff;
        end
        if (ref_h == H_MAX - 1) begin
          ref_h = 0;
          if (ref_v == V_MAX - 1) begin
            ref_v = 0;
            if (!ref_detect) begin
              if (ref_frame == (1 << TRAIN_LOG2) - 1) ref_detect = 1;
              else ref_frame++;
            end
          end else begin
            ref_v++;
          end
        end else begin
          ref_h++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one pixel and returns just after the edge that accepts it; i_valid stays high
  task automatic send_px(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    int n;
    bit done;
    i_r = r; i_g = g; i_b = b; i_valid = 1'b1;
    n = 0;
    done = 0;
    while (!done && n < 200) begin
      @(negedge i_clk);
      n++;
      if (o_ready) begin
        @(posedge i_clk);
        #1;
        done = 1;
      end
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    i_valid = 1'b0;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_ready && n < 100);
    if (!o_ready) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_trained_mem(input string tag);
    for (int p = 0; p < NPIX; p++) begin
      check({tag, "_w0"}, 32'(mem[3 * p]), 32'd200);
      check({tag, "_w1"}, 32'(mem[3 * p + 1]), 32'd20000);
      check({tag, "_w2"}, 32'(mem[3 * p + 2]), 32'd0);
    end
  endtask

  task automatic train_100();
    i_start_train = 1'b1;
    @(posedge i_clk); #1;
    i_start_train = 1'b0;
    for (int i = 0; i < 2 * NPIX; i++) begin
      send_px(10'd400, 10'd400, 10'd400);
      if (i == 2 * NPIX - 1) check("trained_early", 32'(o_trained), 32'd0);
    end
    wait_idle();
    check("trained", 32'(o_trained), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = 16'hbeef;
    i_rst_n = 1'b0; i_valid = 1'b0; i_start_train = 1'b0;
    i_r = '0; i_g = '0; i_b = '0;
    repeat (3) @(negedge i_clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_trained", 32'(o_trained), 32'd0);
    check("rst_fg_valid", 32'(o_fg_valid), 32'd0);
    check("rst_fg", 32'(o_fg), 32'd0);
    check("rst_sram_rd", 32'(o_sram_rd), 32'd0);
    check("rst_sram_wr", 32'(o_sram_wr), 32'd0);
    check("rst_addr", 32'(o_sram_addr), 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // Scenario 1: white pixel, first training frame
    send_px(10'd1023, 10'd1023, 10'd1023);
    wait_idle();
    check("s1_w0", 32'(mem[0]), 32'd255);
    check("s1_w1", 32'(mem[1]), 32'd65025);
    check("s1_w2", 32'(mem[2]), 32'd0);

    // Scenario 2: restart and train on a flat grey scene, valid held high
    train_100();
    check_trained_mem("s2");

    // Scenario 3: detection thresholds
    send_px(10'd400, 10'd400, 10'd400); wait_idle();
    send_px(10'd420, 10'd420, 10'd420); wait_idle();
    send_px(10'd416, 10'd416, 10'd416); wait_idle();

    // Scenario 4: a full detection frame of random pixels with valid held high
    for (int i = 0; i < NPIX + 3; i++) begin
      logic [9:0] x;
      x = 10'($urandom_range(370, 450));
      send_px(x, x, x);
    end
    wait_idle();
    repeat (3) @(negedge i_clk);

    // Scenario 5: restart collides with a pixel in DETECT
    i_r = 10'd400; i_g = 10'd400; i_b = 10'd400;
    i_start_train = 1'b1; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_start_train = 1'b0; i_valid = 1'b0;
    @(negedge i_clk);
    check("s5_no_accept", 32'(o_ready), 32'd1);
    check("s5_trained", 32'(o_trained), 32'd0);
    send_px(10'd1023, 10'd1023, 10'd1023);
    wait_idle();
    check("s5_w0", 32'(mem[0]), 32'd255);
    check("s5_w1", 32'(mem[1]), 32'd65025);

    // Scenario 6: asynchronous reset in the middle of a write sequence
    send_px(10'd400, 10'd400, 10'd400);
    i_valid = 1'b0;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (o_dbg_state != 4'd5 && n < 20);
    check("s6_reach_wr1", 32'(o_dbg_state), 32'd5);
    #1 i_rst_n = 1'b0;
    #1;
    check("s6_sram_wr", 32'(o_sram_wr), 32'd0);
    check("s6_sram_rd", 32'(o_sram_rd), 32'd0);
    check("s6_addr", 32'(o_sram_addr), 32'd0);
    check("s6_ready", 32'(o_ready), 32'd1);
    check("s6_trained", 32'(o_trained), 32'd0);
    check("s6_fg_valid", 32'(o_fg_valid), 32'd0);
    check("s6_dq_z", 32'(sram_dq === 16'hzzzz), 32'd1);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    train_100();
    check_trained_mem("s6");
    send_px(10'd420, 10'd420, 10'd420); wait_idle();
    send_px(10'd400, 10'd400, 10'd400); wait_idle();

    // Drain outstanding detection results
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
